// File: rtl/barrel_pkg.sv
// Shared types for the barrel shifter: shift modes, width helper and the
// beat record that travels down the shift pipeline.
package barrel_pkg;

    typedef enum logic [1:0] {
        LSR = 2'b00,
        ASR = 2'b01,
        ROR = 2'b10,
        RSV = 2'b11
    } shift_mode_t;

    // Data width for a given log2 width.
    function automatic int W(input int n);
        return 1 << n;
    endfunction

    // The beat record is sized for this log2 width; the core's N parameter
    // defaults to it, so retargeting the width means changing BEAT_N here.
    localparam int BEAT_N = 3;
    localparam int BEAT_W = W(BEAT_N);

    typedef struct packed {
        logic [BEAT_W-1:0] data;
        logic              fill;
        logic [BEAT_N-1:0] amt;
        shift_mode_t       mode;
        logic              reverse;
        logic              valid;
    } beat_t;

endpackage

// File: rtl/shift_stage.sv
// One level of the right-shift/rotate pipeline: shifts the beat right by
// 2**K when amt[K] is set, otherwise passes it through. Purely combinational.
module shift_stage
    import barrel_pkg::*;
#(
    parameter int N = BEAT_N,
    parameter int K = 0
) (
    input  beat_t beat_i,
    output beat_t beat_o
);

    localparam int WIDTH = W(N);
    localparam int S     = 1 << K;

    // Rotate recirculates the bits shifted out; other modes use the fill bit.
    always_comb begin
        beat_o = beat_i;
        if (beat_i.amt[K]) begin
            if (beat_i.mode == ROR) begin
                beat_o.data = {beat_i.data[S-1:0], beat_i.data[WIDTH-1:S]};
            end else begin
                beat_o.data = {{S{beat_i.fill}}, beat_i.data[WIDTH-1:S]};
            end
        end
    end

endmodule

// File: rtl/pipelined_shift_core.sv
// Pipelined right-shift/rotate core. One register stage per shift level, all
// stages advance together on a single enable, so bubbles travel with the data.
// Left shifts are done upstream/downstream by bit reversal; the reverse flag
// rides along with each beat to keep the output reverser aligned.
module pipelined_shift_core
    import barrel_pkg::*;
#(
    parameter int N = BEAT_N
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W(N)-1:0] in_data,
    input  logic [N-1:0]    in_amt,
    input  logic [1:0]      in_mode,
    input  logic            in_reverse,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W(N)-1:0] out_data,
    output logic            out_reverse,
    output logic            out_err
);

    localparam int WIDTH = W(N);

    beat_t in_beat;
    beat_t stage_d [N];
    beat_t stage_q [N];
    logic  en;

    assign en       = !stage_q[N-1].valid || out_ready;
    assign in_ready = en;

    // Assemble the entry beat; the fill bit is decided once here. Sign
    // extension only makes sense on un-reversed data.
    always_comb begin
        in_beat         = '0;
        in_beat.data    = in_data;
        in_beat.amt     = in_amt;
        in_beat.mode    = shift_mode_t'(in_mode);
        in_beat.reverse = in_reverse;
        in_beat.valid   = in_valid;
        in_beat.fill    = (shift_mode_t'(in_mode) == ASR) && !in_reverse
                          && in_data[WIDTH-1];
    end

    generate
        for (genvar k = 0; k < N; k++) begin : g_stage
            if (k == 0) begin : g_first
                shift_stage #(.N(N), .K(k)) u_stage (
                    .beat_i (in_beat),
                    .beat_o (stage_d[k])
                );
            end else begin : g_next
                shift_stage #(.N(N), .K(k)) u_stage (
                    .beat_i (stage_q[k-1]),
                    .beat_o (stage_d[k])
                );
            end
        end
    endgenerate

    // Stage registers: cleared on reset, advance together when en, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                stage_q[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < N; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid   = stage_q[N-1].valid;
    assign out_data    = stage_q[N-1].data;
    assign out_reverse = stage_q[N-1].reverse;
    assign out_err     = stage_q[N-1].valid && (stage_q[N-1].mode == RSV);

endmodule

// File: doc/pipelined_shift_core.md
# pipelined_shift_core

Pipelined right-shift/rotate core for the multi-function barrel shifter, W = 2**N bits wide. Sits directly downstream of the input bit-reverser and directly upstream of the output bit-reverser. Left shifts are therefore realised as reverse → right-shift → reverse, and this core always shifts right. It uses one pipeline stage per shift level, a valid/ready handshake on both sides, and forwards the reverse flag alongside the data so the output reverser stays aligned.

## Interface
- N, default 3: log2 of data width; W = 2**N; pipeline depth = N.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input beat present.
- in_ready  out  1  core accepts beat this cycle.
- in_data  in  W  data from the input reverser.
- in_amt  in  N  shift/rotate amount, 0..W-1.
- in_mode  in  2  shift_mode_t: LSR=00, ASR=01, ROR=10, RSV=11.
- in_reverse  in  1  beat was reversed upstream; passed through unchanged.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  W  shifted/rotated result.
- out_reverse  out  1  in_reverse of this beat; drives the output reverser select.
- out_err  out  1  beat carried the RSV mode.

## Operation
- Global advance enable: en = !out_valid || out_ready.
- in_ready = en, combinationally.
- A beat is accepted when in_valid && in_ready.
- When en = 1, every stage register loads from its predecessor, including valid bits.
  - Bubbles propagate; they are not collapsed.
- When en = 0, all stages hold.
- Fill bit is computed once at accept and carried with the beat:
  - ASR with in_reverse=0 → in_data[W-1].
  - ASR with in_reverse=1 → 0, because sign extension is meaningless after reversal.
  - LSR or RSV → 0.
- Stage k (k = 0..N-1): if amt[k] = 1, shift right by 2**k.
  - ROR: vacated bits take the bits shifted out.
  - Other modes: vacated bits take the fill bit.
  - If amt[k] = 0, data passes unchanged.
- RSV behaves as LSR and sets out_err for that beat.
- in_amt = 0 → out_data = in_data in every mode.
- Each beat's mode, fill, reverse and remaining amt bits travel with it. A mix of modes in flight is legal.

## Timing
- Reset values: out_valid=0, out_data=0, out_reverse=0, out_err=0, all stage valids=0. in_ready=1 in the cycle after reset deasserts.
- Latency: a beat accepted at edge t appears on out_valid at edge t+N, provided no stall occurs.
- Throughput: 1 beat/cycle when out_ready is held high.
- Stall: while out_valid=1 and out_ready=0, out_data, out_reverse and out_err hold stable and in_ready=0. No beat is lost or duplicated.
- Simultaneous accept and output: when out_valid && out_ready and a beat is accepted in the same cycle, both transfers occur.
- Reset mid-operation:
  - All in-flight beats are discarded and valids clear on that edge.
  - Input presented during reset is not accepted.
- out_data is meaningful only when out_valid=1, except that it is 0 after reset.

## Structure
- Shared package barrel_pkg holds:
  - typedef enum logic [1:0] shift_mode_t {LSR, ASR, ROR, RSV}.
  - Width function W(N).
  - The beat struct: data, fill, amt, mode, reverse, valid.
- Sub-module shift_stage, parameterised by N and stage index K, is purely combinational:
  - Input: beat struct.
  - Output: beat shifted by 2**K when amt[K] is set.
- Top: N shift_stage instances, each followed by a register stage gated by en. The final register drives the outputs.

## Test plan
- Reset with in_valid=1 for 2 cycles → out_valid=0, out_data=0x00 throughout; in_ready=1 after release; nothing emerges N cycles later.
- N=3, LSR, 0xB4, amt 3 → out_data 0x16 exactly 3 cycles after accept, out_err=0.
- ASR, 0xB4, amt 2, in_reverse=0 → 0xED, out_reverse=0. Same input with in_reverse=1 → 0x2D, out_reverse=1.
- Rotate and reserved mode:
  - ROR, 0x81, amt 1 → 0xC0.
  - ROR, 0x81, amt 0 → 0x81.
  - RSV, 0xF0, amt 4 → 0x0F with out_err=1.
- Backpressure: stream 6 beats back-to-back and drop out_ready for 5 cycles starting at the 4th cycle → in_ready=0 during the stall, out_data held, all 6 results delivered in order with none duplicated.
- Reset mid-stream: 3 beats in flight, reset for 1 cycle → out_valid=0 on the next cycle and none of the 3 appear. A new beat accepted afterwards emerges after exactly N cycles.
